// File: rtl/mole_field_controller_pkg.sv
// Shared types and helpers for the whack-a-mole field controller.
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam int LIFE_MS_BASE_DEFAULT = 1500;
  localparam int LIFE_W = $clog2(LIFE_MS_BASE_DEFAULT + 1);

  function automatic int lifetime_ms(input logic [1:0] level, input int base, input int step);
    return base - int'(level) * step;
  endfunction

endpackage

// File: rtl/mole_field_controller_if.sv
// Game-side signal bundle: spawn/hit requests in, field state and score out.
interface mole_field_controller_if #(
  parameter int NUM_MOLES = 18,
  parameter int SCORE_W   = 11
);
  localparam int IDX_W = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1;

  logic                 start;
  logic [1:0]           level;
  logic                 spawn_req;
  logic [IDX_W-1:0]     spawn_idx;
  logic                 spawn_ack;
  logic [NUM_MOLES-1:0] hit;
  logic [NUM_MOLES-1:0] mole_active;
  logic [SCORE_W-1:0]   score;
  logic [7:0]           misses;
  logic                 playing;
  logic                 game_over;

  modport master (
    output start, level, spawn_req, spawn_idx, hit,
    input  spawn_ack, mole_active, score, misses, playing, game_over
  );

  modport slave (
    input  start, level, spawn_req, spawn_idx, hit,
    output spawn_ack, mole_active, score, misses, playing, game_over
  );
endinterface

// File: rtl/mole_field_controller_slot.sv
// One hole: active flag plus a millisecond down-counter that expires the mole.
module mole_slot #(
  parameter int CNT_W = mole_pkg::LIFE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] life,
  input  logic             tick,
  input  logic             hit,
  output logic             active,
  output logic             expired,
  output logic             scored
);
  logic             active_r;
  logic [CNT_W-1:0] cnt;

  // A hit on the expiring tick wins, so expiry is masked by hit.
  assign scored  = active_r & hit;
  assign expired = active_r & tick & ~hit & (cnt == CNT_W'(1));
  assign active  = active_r;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      active_r <= 1'b0;
      cnt      <= '0;
    end else if (scored || expired) begin
      active_r <= 1'b0;
    end else if (load) begin
      active_r <= 1'b1;
      cnt      <= life;
    end else if (active_r && tick) begin
      cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

// File: rtl/mole_field_controller.sv
// Whack-a-mole game core: game FSM, ms prescaler, per-hole slots, score and miss tally.
module mole_field_controller
  import mole_pkg::*;
#(
  parameter int NUM_MOLES    = 18,
  parameter int MAX_ACTIVE   = 4,
  parameter int TICK_DIV     = 50000,
  parameter int LIFE_MS_BASE = 1500,
  parameter int LIFE_MS_STEP = 300,
  parameter int SCORE_W      = 11,
  parameter int MAX_MISSES   = 10
) (
  input logic              clk,
  input logic              reset,
  mole_field_controller_if.slave bus
);
  localparam int CNT_W  = $clog2(NUM_MOLES + 1);
  localparam int SLOT_W = $clog2(LIFE_MS_BASE + 1);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SUM_W  = SCORE_W + 9;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  game_state_t state, state_nxt;
  logic [TICK_W-1:0]    presc;
  logic                 playing, tick, spawn_ok, start_game, enter_over;
  logic [NUM_MOLES-1:0] active_v, expired_v, scored_v, load_v;
  logic [CNT_W-1:0]     n_active, n_hit, n_exp;
  logic [SCORE_W-1:0]   score_r, score_nxt;
  logic [SUM_W-1:0]     score_sum;
  logic [7:0]           misses_r, misses_nxt;
  logic [8:0]           misses_sum;
  logic                 ack_r;
  logic [SLOT_W-1:0]    life_ld;

  assign playing = (state == PLAY);
  assign tick    = playing && (presc == TICK_W'(TICK_DIV - 1));
  assign life_ld = SLOT_W'(lifetime_ms(bus.level, LIFE_MS_BASE, LIFE_MS_STEP));

  always_comb begin
    n_active = '0;
    n_hit    = '0;
    n_exp    = '0;
    for (int i = 0; i < NUM_MOLES; i++) begin
      n_active = n_active + CNT_W'(active_v[i]);
      n_hit    = n_hit + CNT_W'(scored_v[i]);
      n_exp    = n_exp + CNT_W'(expired_v[i]);
    end
  end

  // Occupancy is judged on the start-of-cycle field, so a same-cycle hit does not free a slot.
  assign spawn_ok = playing && bus.spawn_req && (32'(bus.spawn_idx) < NUM_MOLES)
                    && !active_v[bus.spawn_idx] && (32'(n_active) < MAX_ACTIVE);
  assign load_v   = spawn_ok ? (NUM_MOLES'(1) << bus.spawn_idx) : '0;

  always_comb begin
    score_sum  = SUM_W'(score_r) + SUM_W'(n_hit) * (SUM_W'(bus.level) + SUM_W'(1));
    score_nxt  = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
    misses_sum = {1'b0, misses_r} + 9'(n_exp);
    misses_nxt = (misses_sum >= 9'(MAX_MISSES)) ? 8'(MAX_MISSES) : misses_sum[7:0];
  end

  for (genvar g = 0; g < NUM_MOLES; g++) begin : g_slot
    mole_slot #(.CNT_W(SLOT_W)) u_slot (
      .clk    (clk),
      .reset  (reset),
      .clear  (start_game | enter_over),
      .load   (load_v[g]),
      .life   (life_ld),
      .tick   (tick),
      .hit    (bus.hit[g] & playing),
      .active (active_v[g]),
      .expired(expired_v[g]),
      .scored (scored_v[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_game = 1'b0;
    enter_over = 1'b0;
    case (state)
      IDLE, OVER: begin
        if (bus.start) begin
          start_game = 1'b1;
          state_nxt  = PLAY;
        end
      end
      PLAY: begin
        if (misses_nxt == 8'(MAX_MISSES)) begin
          enter_over = 1'b1;
          state_nxt  = OVER;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc    <= '0;
      score_r  <= '0;
      misses_r <= '0;
      ack_r    <= 1'b0;
    end else begin
      ack_r <= spawn_ok;
      presc <= (playing && !tick) ? presc + TICK_W'(1) : '0;
      if (start_game) begin
        score_r  <= '0;
        misses_r <= '0;
      end else if (playing) begin
        score_r  <= score_nxt;
        misses_r <= misses_nxt;
      end
    end
  end

  assign bus.spawn_ack   = ack_r;
  assign bus.mole_active = active_v;
  assign bus.score       = score_r;
  assign bus.misses      = misses_r;
  assign bus.playing     = playing;
  assign bus.game_over   = (state == OVER);
endmodule

// File: tb/tb_mole_field_controller.sv
// Directed bench for mole_field_controller with a per-cycle behavioural game model.
module tb_mole_field_controller;
  localparam int NM   = 8;
  localparam int MA   = 2;
  localparam int TD   = 4;
  localparam int LB   = 10;
  localparam int LS   = 3;
  localparam int SW   = 11;
  localparam int MM   = 3;
  localparam int SMAX = 2047;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  mole_field_controller_if #(.NUM_MOLES(NM), .SCORE_W(SW)) bus ();

  mole_field_controller #(
    .NUM_MOLES(NM), .MAX_ACTIVE(MA), .TICK_DIV(TD), .LIFE_MS_BASE(LB),
    .LIFE_MS_STEP(LS), .SCORE_W(SW), .MAX_MISSES(MM)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 play, 2 over; per-hole remaining ms.
  int       m_state = 0;
  bit [7:0] m_act   = 0;
  int       m_life[NM];
  int       m_score = 0;
  int       m_miss  = 0;
  int       m_presc = 0;
  bit       m_ack   = 0;

  always @(posedge clk) begin
    bit [7:0] nact;
    int nh, ne, cnt, idx, lv;
    bit tk;
    if (reset) begin
      m_state = 0; m_act = 0; m_score = 0; m_miss = 0; m_presc = 0; m_ack = 0;
    end else if (m_state != 1) begin
      m_ack = 0;
      if (bus.start) begin
        m_state = 1; m_act = 0; m_score = 0; m_miss = 0; m_presc = 0;
      end
    end else begin
      tk   = (m_presc == TD - 1);
      nact = m_act;
      nh   = 0;
      ne   = 0;
      cnt  = $countones(m_act);
      lv   = int'(bus.level);
      for (int i = 0; i < NM; i++) begin
        if (m_act[i]) begin
          if (bus.hit[i]) begin
            nact[i] = 0; nh++;
          end else if (tk) begin
            if (m_life[i] == 1) begin
              nact[i] = 0; ne++;
            end else begin
              m_life[i]--;
            end
          end
        end
      end
      idx   = int'(bus.spawn_idx);
      m_ack = 0;
      if (bus.spawn_req && idx < NM && !m_act[idx] && cnt < MA) begin
        nact[idx]   = 1;
        m_life[idx] = LB - lv * LS;
        m_ack       = 1;
      end
      m_score = m_score + nh * (lv + 1);
      if (m_score > SMAX) m_score = SMAX;
      m_miss = m_miss + ne;
      if (m_miss > MM) m_miss = MM;
      m_presc = (m_presc + 1) % TD;
      if (m_miss == MM) begin
        m_state = 2; nact = 0; m_presc = 0;
      end
      m_act = nact;
    end
  end

  always @(posedge clk) begin
    #1;
    check("mdl_mole_active", 32'(bus.mole_active), 32'(m_act));
    check("mdl_score", 32'(bus.score), 32'(m_score));
    check("mdl_misses", 32'(bus.misses), 32'(m_miss));
    check("mdl_spawn_ack", 32'(bus.spawn_ack), 32'(m_ack));
    check("mdl_playing", 32'(bus.playing), 32'(m_state == 1));
    check("mdl_game_over", 32'(bus.game_over), 32'(m_state == 2));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic spawn(input int idx);
    bus.spawn_req = 1'b1;
    bus.spawn_idx = 3'(idx);
    step();
    bus.spawn_req = 1'b0;
  endtask

  task automatic hit_pulse(input logic [7:0] v);
    bus.hit = v;
    step();
    bus.hit = '0;
  endtask

  task automatic restart();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mole_active"}, 32'(bus.mole_active), 0);
    check({tag, "_score"}, 32'(bus.score), 0);
    check({tag, "_misses"}, 32'(bus.misses), 0);
    check({tag, "_spawn_ack"}, 32'(bus.spawn_ack), 0);
    check({tag, "_playing"}, 32'(bus.playing), 0);
    check({tag, "_game_over"}, 32'(bus.game_over), 0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    bus.start = 1'b0; bus.level = 2'd0; bus.spawn_req = 1'b0;
    bus.spawn_idx = '0; bus.hit = '0;
    step();
    step();
    check_all_zero("reset");
    reset = 1'b0;

    // Level-0 mole runs its full 10 ms lifetime.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("start_playing", 32'(bus.playing), 1);
    spawn(5);
    check("spawn5_active", 32'(bus.mole_active), 32'h20);
    check("spawn5_ack", 32'(bus.spawn_ack), 1);
    n = 0;
    while (bus.mole_active != 0 && n < 60) begin
      step();
      n++;
    end
    check("expire_cycles", 32'(n), 39);
    check("expire_misses", 32'(bus.misses), 1);

    // Level-2 hit scores 3.
    restart();
    bus.level = 2'd2;
    spawn(2);
    repeat (4) step();
    hit_pulse(8'h04);
    check("hit2_active", 32'(bus.mole_active), 0);
    check("hit2_score", 32'(bus.score), 3);
    check("hit2_misses", 32'(bus.misses), 0);

    // MAX_ACTIVE limit, ignored hit, double hit.
    bus.level = 2'd1;
    spawn(0);
    spawn(1);
    spawn(3);
    check("cap_active", 32'(bus.mole_active), 32'h03);
    check("cap_no_ack", 32'(bus.spawn_ack), 0);
    hit_pulse(8'h08);
    check("idle_hit_score", 32'(bus.score), 3);
    hit_pulse(8'h03);
    check("double_hit_score", 32'(bus.score), 7);
    check("double_hit_active", 32'(bus.mole_active), 0);

    // Hit lands on the same tick the mole would expire.
    bus.level = 2'd3;
    n = 0;
    while (m_presc != 2 && n < 10) begin
      step();
      n++;
    end
    spawn(4);
    hit_pulse(8'h10);
    check("hit_vs_expire_score", 32'(bus.score), 11);
    check("hit_vs_expire_misses", 32'(bus.misses), 0);

    // Three expiries end the game.
    spawn(0);
    spawn(1);
    n = 0;
    while (bus.mole_active != 0 && n < 20) begin
      step();
      n++;
    end
    check("two_expired_misses", 32'(bus.misses), 2);
    spawn(2);
    n = 0;
    while (!bus.game_over && n < 20) begin
      step();
      n++;
    end
    check("over_game_over", 32'(bus.game_over), 1);
    check("over_playing", 32'(bus.playing), 0);
    check("over_active", 32'(bus.mole_active), 0);
    check("over_score_held", 32'(bus.score), 11);
    check("over_misses", 32'(bus.misses), 3);
    spawn(5);
    check("over_spawn_active", 32'(bus.mole_active), 0);
    check("over_spawn_ack", 32'(bus.spawn_ack), 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("restart_score", 32'(bus.score), 0);
    check("restart_misses", 32'(bus.misses), 0);
    check("restart_playing", 32'(bus.playing), 1);

    // Pump the score past 2047 with level-3 hits, one per cycle.
    bus.level = 2'd3;
    for (int k = 0; k <= 520; k++) begin
      bus.spawn_req = 1'b1;
      bus.spawn_idx = 3'(k % 2);
      bus.hit       = (k > 0) ? 8'(1 << ((k - 1) % 2)) : 8'h00;
      step();
    end
    bus.spawn_req = 1'b0;
    bus.level = 2'd0;
    hit_pulse(8'h01);
    check("score_saturated", 32'(bus.score), 2047);
    check("sat_misses", 32'(bus.misses), 0);

    // Reset mid-game with two moles lit.
    spawn(6);
    spawn(7);
    check("pre_reset_active", 32'(bus.mole_active), 32'hC0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all_zero("midreset");
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("idle_after_reset_start", 32'(bus.playing), 1);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
